// File: rtl/dmem_wbuf_bridge.sv
// dmem_wbuf_bridge: CPU data-port bridge with a FIFO write buffer.
// Stores are posted into a DEPTH-entry buffer and drained to memory in order.
// A load that is not forwarded waits until every older store has been written,
// then performs a single memory read.
// Optional feature macro: DMEM_WBUF_FWD_EN (store-to-load forwarding from the buffer).
module dmem_wbuf_bridge #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_READ,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [29:0]   ld_addr_q, ld_addr_d;

    logic [29:0]   buf_addr_q [DEPTH];
    logic [31:0]   buf_data_q [DEPTH];

    logic          push, pop;
    logic          load_req, store_req;
    logic          not_empty, not_full;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          unused_addr_bits;

    assign load_req         = cpu_req & ~cpu_wen;
    assign store_req        = cpu_req & cpu_wen;
    assign not_empty        = (count_q != '0);
    assign not_full         = (count_q < DEPTH_C);
    assign unused_addr_bits = ^cpu_addr[1:0];

`ifdef DMEM_WBUF_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Youngest matching valid entry wins: scan oldest to youngest, later hits overwrite.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (buf_addr_q[fwd_idx] == cpu_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[fwd_idx];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // Next-state, buffer control and command outputs; reset forces all outputs quiet.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        ld_addr_d = ld_addr_q;
        push      = 1'b0;
        pop       = 1'b0;
        cpu_stall = 1'b0;
        cpu_rdata = rdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (not_empty) begin
                    mem_write = 1'b1;
                    mem_addr  = {buf_addr_q[rd_ptr_q], 2'b00};
                    mem_wdata = buf_data_q[rd_ptr_q];
                    pop       = mem_ready;
                end
                if (store_req) begin
                    // Full test uses the registered count, so a same-cycle pop never frees a slot.
                    if (not_full) push = 1'b1;
                    else          cpu_stall = 1'b1;
                end else if (load_req) begin
                    if (fwd_hit) begin
                        cpu_rdata = fwd_data;
                    end else begin
                        cpu_stall = 1'b1;
                        ld_addr_d = cpu_addr[31:2];
                        state_d   = not_empty ? S_DRAIN : S_READ;
                    end
                end
            end
            S_DRAIN: begin
                cpu_stall = 1'b1;
                if (not_empty) begin
                    mem_write = 1'b1;
                    mem_addr  = {buf_addr_q[rd_ptr_q], 2'b00};
                    mem_wdata = buf_data_q[rd_ptr_q];
                    pop       = mem_ready;
                    if (mem_ready && (count_q == ONE_C)) state_d = S_READ;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cpu_stall = 1'b1;
                mem_read  = 1'b1;
                mem_addr  = {ld_addr_q, 2'b00};
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cpu_rdata = rdata_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!rst_n) begin
            push      = 1'b0;
            pop       = 1'b0;
            cpu_stall = 1'b0;
            cpu_rdata = '0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // Pointer and occupancy update; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + ONE_C;
        else if (pop && !push) count_d = count_q - ONE_C;
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rdata_q   <= '0;
            ld_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rdata_q   <= rdata_d;
            ld_addr_q <= ld_addr_d;
        end
    end

    // Buffer storage; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= cpu_addr[31:2];
            buf_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_wbuf_bridge.sv
// Directed self-checking bench for dmem_wbuf_bridge (DEPTH=4).
// Checks adapt to DMEM_WBUF_FWD_EN where forwarding changes behaviour.
module tb_dmem_wbuf_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model and command log, driven only by the monitor process
    logic [31:0] mem [1024];
    logic [31:0] wlog_addr [64];
    logic [31:0] wlog_data [64];
    int          wlog_ord  [64];
    int          wcnt = 0;
    int          rd_cnt = 0;
    int          rd_ord = 0;
    logic [31:0] rd_addr = '0;
    int          ev_n = 0;
    logic        both_seen = 1'b0;

    dmem_wbuf_bridge #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // fixed words at 0x100 and 0x80, everything else from written memory
    assign mem_rdata = (mem_addr == 32'h100) ? 32'hDEADBEEF :
                       (mem_addr == 32'h80)  ? 32'h12345678 :
                       mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_read && mem_write) both_seen <= 1'b1;
        if (mem_write && mem_ready) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            wlog_addr[wcnt]     <= mem_addr;
            wlog_data[wcnt]     <= mem_wdata;
            wlog_ord[wcnt]      <= ev_n;
            wcnt                <= wcnt + 1;
            ev_n                <= ev_n + 1;
        end
        if (mem_read && mem_ready) begin
            rd_addr <= mem_addr;
            rd_ord  <= ev_n;
            rd_cnt  <= rd_cnt + 1;
            ev_n    <= ev_n + 1;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h100;
        cpu_wdata = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (mem_read !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %b expected 0", mem_write); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", cpu_stall); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", cpu_rdata); end
        @(posedge clk); #1;
        cpu_req = 1'b0; rst_n = 1'b1; #1;
        n_checks++; if (cpu_stall !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got stall=%b wr=%b expected 0 0", cpu_stall, mem_write); end
    endtask

    task automatic test_load_latency;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h100; #1;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL lat_c0_stall: got %b expected 1", cpu_stall); end
        n_checks++; if (mem_read !== 1'b0)  begin n_fail++; $display("FAIL lat_c0_noread: got %b expected 0", mem_read); end
        @(posedge clk); #2;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL lat_c1_stall: got %b expected 1", cpu_stall); end
        n_checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL lat_c1_read: got rd=%b addr=%h expected 1 00000100", mem_read, mem_addr); end
        @(posedge clk); #2;
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL lat_resp_stall: got %b expected 0", cpu_stall); end
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat_resp_data: got %h expected deadbeef", cpu_rdata); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_store_full;
        int base;
        bit done;
        base = wcnt;
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            cpu_req = 1'b1; cpu_wen = 1'b1;
            cpu_addr = 32'h200 + 32'(4 * k); cpu_wdata = 32'hA0 + 32'(k); #1;
            n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL full_accept%0d: got stall %b expected 0", k, cpu_stall); end
        end
        @(posedge clk); #1;
        cpu_addr = 32'h210; cpu_wdata = 32'hA4; #1;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL full_5th_stall: got %b expected 1", cpu_stall); end
        n_checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hA0) begin
            n_fail++; $display("FAIL full_oldest_cmd: got wr=%b addr=%h data=%h expected 1 00000200 000000a0", mem_write, mem_addr, mem_wdata); end
        repeat (2) begin
            @(posedge clk); #2;
            n_checks++; if (cpu_stall !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL full_hold: got stall=%b addr=%h expected 1 00000200", cpu_stall, mem_addr); end
        end
        @(posedge clk); #1;
        mem_ready = 1'b1; #1;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL full_samecycle_pop: got stall %b expected 1", cpu_stall); end
        @(posedge clk); #2;
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL full_5th_accept: got stall %b expected 0", cpu_stall); end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (wcnt - base == 5) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL full_drain_timeout: got %0d writes expected 5", wcnt - base); end
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (wlog_addr[base+j] !== 32'h200 + 32'(4 * j) || wlog_data[base+j] !== 32'hA0 + 32'(j)) begin
                n_fail++; $display("FAIL full_order%0d: got %h/%h expected %h/%h", j, wlog_addr[base+j], wlog_data[base+j], 32'h200 + 32'(4 * j), 32'hA0 + 32'(j)); end
        end
    endtask

    task automatic test_store_then_load;
        int bw, br;
        bit done;
        bw = wcnt; br = rd_cnt;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h11; #1;
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL stld_store: got stall %b expected 0", cpu_stall); end
        @(posedge clk); #1;
        cpu_wen = 1'b0; #1;
`ifdef DMEM_WBUF_FWD_EN
        n_checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h11) begin n_fail++; $display("FAIL stld_fwd: got stall=%b data=%h expected 0 00000011", cpu_stall, cpu_rdata); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rd_cnt != br) begin n_fail++; $display("FAIL stld_fwd_noread: got %0d reads expected 0", rd_cnt - br); end
`else
        n_checks++; if (cpu_stall !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL stld_drain_first: got stall=%b wr=%b addr=%h expected 1 1 00000040", cpu_stall, mem_write, mem_addr); end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #2;
            if (!cpu_stall) done = 1'b1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL stld_timeout: got stall 1 expected 0"); end
        n_checks++; if (cpu_rdata !== 32'h11) begin n_fail++; $display("FAIL stld_data: got %h expected 00000011", cpu_rdata); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        n_checks++; if (rd_cnt - br != 1 || rd_addr !== 32'h40) begin n_fail++; $display("FAIL stld_read: got %0d reads addr %h expected 1 00000040", rd_cnt - br, rd_addr); end
        n_checks++; if (wcnt - bw != 1 || wlog_addr[bw] !== 32'h40 || wlog_ord[bw] >= rd_ord) begin
            n_fail++; $display("FAIL stld_order: got writes=%0d addr=%h word=%0d read=%0d expected write 00000040 before read", wcnt - bw, wlog_addr[bw], wlog_ord[bw], rd_ord); end
`endif
    endtask

    task automatic test_read_wait;
        int stalls, rdcyc;
        bit addr_ok, done;
        stalls = 0; rdcyc = 0; addr_ok = 1'b1; done = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h82;
        for (int i = 0; i < 20 && !done; i++) begin
            mem_ready = (i >= 4); #1;
            if (cpu_stall) begin
                stalls++;
                if (mem_read) begin
                    rdcyc++;
                    if (mem_addr !== 32'h80) addr_ok = 1'b0;
                end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL rw_timeout: got stall 1 expected 0"); end
        n_checks++; if (stalls != 5) begin n_fail++; $display("FAIL rw_stalls: got %0d expected 5", stalls); end
        n_checks++; if (rdcyc != 4 || !addr_ok) begin n_fail++; $display("FAIL rw_addr: got %0d read cycles stable=%b expected 4 1", rdcyc, addr_ok); end
        n_checks++; if (cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rw_data: got %h expected 12345678", cpu_rdata); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_drain;
        int base;
        base = wcnt;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h55;
        @(posedge clk); #1;
        cpu_addr = 32'h304; cpu_wdata = 32'h66;
        @(posedge clk); #1;
        cpu_wen = 1'b0; cpu_addr = 32'h400; #1;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rd_load_stall: got %b expected 1", cpu_stall); end
        @(posedge clk); #2;
        n_checks++; if (cpu_stall !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'h300) begin
            n_fail++; $display("FAIL rd_in_drain: got stall=%b wr=%b addr=%h expected 1 1 00000300", cpu_stall, mem_write, mem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ready = 1'b1; #1;
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rd_during_rst: got wr %b expected 0", mem_write); end
        @(posedge clk); #1;
        rst_n = 1'b1; cpu_req = 1'b0; #1;
        n_checks++; if (mem_write !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rd_after_rst: got wr=%b stall=%b expected 0 0", mem_write, cpu_stall); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (wcnt != base) begin n_fail++; $display("FAIL rd_no_write: got %0d writes expected 0", wcnt - base); end
    endtask

    task automatic test_fwd_youngest;
        int base;
        bit done;
        base = wcnt;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h1;
        @(posedge clk); #1;
        cpu_addr = 32'h504; cpu_wdata = 32'h2;
        @(posedge clk); #1;
        cpu_addr = 32'h500; cpu_wdata = 32'h3;
        @(posedge clk); #1;
        cpu_wen = 1'b0; #1;
`ifdef DMEM_WBUF_FWD_EN
        n_checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h3) begin n_fail++; $display("FAIL yng_fwd: got stall=%b data=%h expected 0 00000003", cpu_stall, cpu_rdata); end
`else
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL yng_stall: got %b expected 1", cpu_stall); end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            mem_ready = 1'b1; #1;
            if (!cpu_stall) done = 1'b1;
        end
        n_checks++; if (!done || cpu_rdata !== 32'h3) begin n_fail++; $display("FAIL yng_mem: got done=%b data=%h expected 1 00000003", done, cpu_rdata); end
`endif
        @(posedge clk); #1;
        cpu_req = 1'b0; mem_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (wcnt - base == 3) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL yng_drain: got %0d writes expected 3", wcnt - base); end
        n_checks++; if (wlog_data[base] !== 32'h1 || wlog_data[base+1] !== 32'h2 || wlog_data[base+2] !== 32'h3 || wlog_addr[base+2] !== 32'h500) begin
            n_fail++; $display("FAIL yng_order: got %h %h %h@%h expected 1 2 3@00000500", wlog_data[base], wlog_data[base+1], wlog_data[base+2], wlog_addr[base+2]); end
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_store_full();
        test_store_then_load();
        test_read_wait();
        test_reset_drain();
        test_fwd_youngest();
        n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL rd_wr_exclusive: got both asserted expected never"); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf_bridge.md
DMEM_WBUF_BRIDGE -- requirements
Module: dmem_wbuf_bridge

Interface
REQ-001 Parameter DEPTH, default 4, write-buffer entries; SHALL be a power of two, at least 2.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 Port cpu_req, input, 1: CPU data access valid this cycle.
REQ-005 Port cpu_wen, input, 1: 1 = store, 0 = load; qualified by cpu_req.
REQ-006 Port cpu_addr, input, 32: byte address; bits [1:0] SHALL be ignored and driven as 0 on mem_addr.
REQ-007 Port cpu_wdata, input, 32: store data.
REQ-008 Port cpu_rdata, output, 32: load data; valid only when the load is not stalled.
REQ-009 Port cpu_stall, output, 1: 1 = CPU holds PC, register state and request unchanged.
REQ-010 Ports mem_read / mem_write, output, 1 each: memory command; never both 1.
REQ-011 Port mem_addr, output, 32: word-aligned memory address.
REQ-012 Port mem_wdata, output, 32: memory write data.
REQ-013 Port mem_rdata, input, 32: memory read data; valid when mem_ready=1 during a read.
REQ-014 Port mem_ready, input, 1: command completes on the rising edge where mem_ready=1.

Function
REQ-015 Stores SHALL enter a FIFO write buffer; a store is accepted on the edge where cpu_req=1, cpu_wen=1 and count<DEPTH, with cpu_stall=0 that cycle.
REQ-016 Store with count==DEPTH: cpu_stall=1 until count<DEPTH; a same-cycle pop SHALL NOT permit the push.
REQ-017 FSM states: IDLE, DRAIN, READ, RESP.
REQ-018 IDLE: if count>0, the oldest entry SHALL be presented on mem_write/mem_addr/mem_wdata and popped on the edge where mem_ready=1.
REQ-019 IDLE, load miss (no forward hit), count>0: cpu_stall=1, go to DRAIN.
REQ-020 IDLE, load miss, count==0: cpu_stall=1, go to READ.
REQ-021 DRAIN: write entries as in REQ-018; go to READ on the edge that pops the last entry.
REQ-022 READ: mem_read=1 with mem_addr held stable; on mem_ready=1, register mem_rdata and go to RESP.
REQ-023 RESP: cpu_stall=0, cpu_rdata=registered data, return to IDLE.
REQ-024 Load latency with an empty buffer and zero wait states: the load is stalled for exactly 2 cycles, then completes in RESP; each memory wait cycle adds one cycle.
REQ-025 Commands SHALL keep address and data stable until mem_ready=1; outputs SHALL NOT change mid-command.
REQ-026 The count and the read/write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-027 Memory write order SHALL equal store acceptance order; no load SHALL read memory while an older store is still buffered.
REQ-028 cpu_req=0: no push, cpu_stall=0; draining continues.

Reset
REQ-029 On the edge where rst_n=0: state=IDLE, count=0, pointers=0, read-data register=0; buffered stores discarded.
REQ-030 During and after reset: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0.
REQ-031 Reset mid-command SHALL abandon the command; a later mem_ready SHALL be ignored.

Configuration
REQ-032 Macro DMEM_WBUF_FWD_EN defined: a load in IDLE whose word address matches any valid buffered entry SHALL return the data of the youngest match combinationally, with cpu_stall=0 and no memory access.
REQ-033 Macro DMEM_WBUF_FWD_EN undefined: no forwarding; every load follows REQ-019 to REQ-023.

Verification
REQ-034 Reset, then a load of 0x100 with memory word 0x100=0xDEADBEEF and mem_ready always 1 -> cpu_stall=1 for 2 cycles; the RESP cycle returns cpu_rdata=0xDEADBEEF.
REQ-035 Five back-to-back stores with DEPTH=4 and mem_ready held 0 -> the first four accepted without stall; the fifth stalls until mem_ready=1 pops one entry.
REQ-036 Store 0x11 to 0x40, then load 0x40, mem_ready=1 -> with FWD: cpu_rdata=0x11 in the same cycle, mem_read never asserted; without FWD: mem_write 0x40 precedes mem_read 0x40, returning 0x11.
REQ-037 mem_ready held 0 for 3 cycles during READ -> mem_addr stable throughout; cpu_stall=1 for 5 cycles total.
REQ-038 rst_n=0 asserted in DRAIN with 2 entries buffered -> next cycle mem_write=0, count=0, state=IDLE; no write reaches memory.
REQ-039 Stores A=1, B=2, A=3, then load A with FWD -> returns 3, the youngest match.
